// File: rtl/ipgu_pyramid.sv
// ipgu_pyramid: builds an image pyramid from a square source image held in
// an external single-port RAM. Each level is a nearest-neighbour resample of
// the source, using a per-level fixed-point step. The unit emits every
// WIN_DIM x WIN_DIM window of every active level, one row per handshake.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_we/cfg_level/...         level table write port (ignored while busy)
//   cfg_num_levels               number of active levels, sampled on start
//   start, abort                 begin a pass / drop back to idle
//   busy, done                   pass in progress / one-cycle completion pulse
//   ram_rd, ram_addr, ram_rdata  source RAM read port (data one cycle later)
//   out_valid, out_ready         row handshake toward the consumer
//   out_row                      packed row, pixel 0 in the LSBs
//   out_level/out_win_x/out_win_y/out_row_idx/out_last  row tags
module ipgu_pyramid #(
  parameter int IMG_DIM    = 300,
  parameter int WIN_DIM    = 20,
  parameter int MAX_LEVELS = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 6,
  parameter int STEP_WIDTH = 12,
  localparam int AW = $clog2(IMG_DIM*IMG_DIM),
  localparam int LW = $clog2(MAX_LEVELS),
  localparam int CW = $clog2(IMG_DIM/WIN_DIM+1),
  localparam int WW = $clog2(WIN_DIM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [LW-1:0]                 cfg_level,
  input  logic [CW-1:0]                 cfg_num_win,
  input  logic [STEP_WIDTH-1:0]         cfg_step,
  input  logic [LW:0]                   cfg_num_levels,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          ram_rd,
  output logic [AW-1:0]                 ram_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIN_DIM*DATA_WIDTH-1:0] out_row,
  output logic [LW-1:0]                 out_level,
  output logic [CW-1:0]                 out_win_x,
  output logic [CW-1:0]                 out_win_y,
  output logic [WW-1:0]                 out_row_idx,
  output logic                          out_last
);

  localparam int LVW = LW + 1;                    // level index incl. "none" value
  localparam int PXW = CW + WW;                   // level-pixel coordinate
  localparam int PW  = CW + WW + STEP_WIDTH;      // coordinate * step product
  localparam int RW  = WIN_DIM * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_DATA, S_PRESENT} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_tab_num  [MAX_LEVELS];
  logic [STEP_WIDTH-1:0] r_tab_step [MAX_LEVELS];
  logic [LVW-1:0]        r_num_levels;
  logic [LW-1:0]         r_level;
  logic [CW-1:0]         r_win_x, r_win_y;
  logic [WW-1:0]         r_row, r_col;
  logic                  r_cap;
  logic [RW-1:0]         r_row_buf;
  logic                  r_done;

  // Level table. NOTE: this is a register array, not a RAM macro, so it can
  // take the asynchronous reset; software relies on it reading all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEVELS; i++) begin
        r_tab_num[i]  <= '0;
        r_tab_step[i] <= '0;
      end
    end else if (cfg_we && r_state == S_IDLE) begin
      r_tab_num[cfg_level]  <= cfg_num_win;
      r_tab_step[cfg_level] <= cfg_step;
    end
  end

  // Lowest level >= from that is both below the level count and non-empty.
  // Returns MAX_LEVELS when no such level exists.
  function automatic logic [LVW-1:0] find_level(input logic [LVW-1:0] from,
                                                input logic [LVW-1:0] cnt);
    logic [LVW-1:0] res;
    res = LVW'(MAX_LEVELS);
    for (int i = MAX_LEVELS - 1; i >= 0; i--) begin
      if (LVW'(i) >= from && LVW'(i) < cnt && r_tab_num[i] != '0) res = LVW'(i);
    end
    return res;
  endfunction

  logic [CW-1:0]         w_cur_num;
  logic [STEP_WIDTH-1:0] w_cur_step;
  logic [LVW-1:0]        w_first_lvl, w_next_lvl;
  logic                  w_start_ok, w_hs;
  logic                  w_row_end, w_x_end, w_y_end, w_last_row;

  assign w_cur_num   = r_tab_num[r_level];
  assign w_cur_step  = r_tab_step[r_level];
  assign w_start_ok  = start && !abort && r_state == S_IDLE;
  assign w_first_lvl = find_level('0, cfg_num_levels);
  assign w_next_lvl  = find_level(LVW'(r_level) + LVW'(1), r_num_levels);
  assign w_hs        = r_state == S_PRESENT && out_ready && !abort;
  assign w_row_end   = r_row == WW'(WIN_DIM - 1);
  assign w_x_end     = r_win_x == w_cur_num - CW'(1);
  assign w_y_end     = r_win_y == w_cur_num - CW'(1);
  assign w_last_row  = w_row_end && w_x_end && w_y_end && (w_next_lvl == LVW'(MAX_LEVELS));

  // Source address of the pixel fetched this cycle: scale, truncate, clamp.
  logic [PXW-1:0] w_px, w_py;
  logic [PW-1:0]  w_prod_x, w_prod_y, w_sx_sh, w_sy_sh;
  logic [AW-1:0]  w_sx, w_sy, w_addr;

  assign w_px     = PXW'(r_win_x) * PXW'(WIN_DIM) + PXW'(r_col);
  assign w_py     = PXW'(r_win_y) * PXW'(WIN_DIM) + PXW'(r_row);
  assign w_prod_x = PW'(w_px) * PW'(w_cur_step);
  assign w_prod_y = PW'(w_py) * PW'(w_cur_step);
  assign w_sx_sh  = w_prod_x >> FRAC_BITS;
  assign w_sy_sh  = w_prod_y >> FRAC_BITS;
  assign w_sx     = (w_sx_sh > PW'(IMG_DIM - 1)) ? AW'(IMG_DIM - 1) : w_sx_sh[AW-1:0];
  assign w_sy     = (w_sy_sh > PW'(IMG_DIM - 1)) ? AW'(IMG_DIM - 1) : w_sy_sh[AW-1:0];
  assign w_addr   = w_sy * AW'(IMG_DIM) + w_sx;

  // NOTE: state and every other register use non-blocking assignments so all
  // flops sample the same pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default is assigned before the case so no path leaves
  // w_state_nxt unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_start_ok && w_first_lvl != LVW'(MAX_LEVELS)) w_state_nxt = S_FETCH;
      S_FETCH:     if (r_col == WW'(WIN_DIM - 1)) w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: w_state_nxt = S_PRESENT;
      S_PRESENT:   if (out_ready) w_state_nxt = w_last_row ? S_IDLE : S_FETCH;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Position counters: column within the fetch, then row/window/level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_levels <= '0;
      r_level      <= '0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_row        <= '0;
      r_col        <= '0;
    end else if (abort) begin
      r_col <= '0;
    end else if (w_start_ok) begin
      r_num_levels <= cfg_num_levels;
      r_level      <= w_first_lvl[LW-1:0];
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_row        <= '0;
      r_col        <= '0;
    end else if (r_state == S_FETCH) begin
      r_col <= (r_col == WW'(WIN_DIM - 1)) ? '0 : r_col + 1'b1;
    end else if (w_hs) begin
      if (!w_row_end) begin
        r_row <= r_row + 1'b1;
      end else begin
        r_row <= '0;
        if (!w_x_end) begin
          r_win_x <= r_win_x + 1'b1;
        end else begin
          r_win_x <= '0;
          if (!w_y_end) begin
            r_win_y <= r_win_y + 1'b1;
          end else begin
            r_win_y <= '0;
            if (w_next_lvl != LVW'(MAX_LEVELS)) r_level <= w_next_lvl[LW-1:0];
          end
        end
      end
    end
  end

  // r_cap marks the cycle in which ram_rdata holds a pixel we asked for.
  // Pixels enter at the top and shift down, so the first read lands in the LSBs.
  // Clearing r_cap on abort drops the read that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap     <= 1'b0;
      r_row_buf <= '0;
      r_done    <= 1'b0;
    end else begin
      r_cap  <= ram_rd && !abort;
      r_done <= !abort && ((w_start_ok && w_first_lvl == LVW'(MAX_LEVELS)) ||
                           (w_hs && w_last_row));
      if (r_cap) r_row_buf <= {ram_rdata, r_row_buf[RW-1:DATA_WIDTH]};
    end
  end

  assign busy        = r_state != S_IDLE;
  assign done        = r_done;
  assign ram_rd      = r_state == S_FETCH;
  assign ram_addr    = ram_rd ? w_addr : '0;
  assign out_valid   = r_state == S_PRESENT;
  assign out_row     = r_row_buf;
  assign out_level   = r_level;
  assign out_win_x   = r_win_x;
  assign out_win_y   = r_win_y;
  assign out_row_idx = r_row;
  assign out_last    = w_row_end;

endmodule
